// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, 8 data bits LSB first, even parity, one stop bit.
// Data and error flags are registered on the stop-bit evaluation tick; Rx_VALID pulses only for clean frames.
module uart_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       Rx_sample_ENABLE,
    input  logic       Rx_D,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_n;
    logic [1:0]  sync;
    logic        rx_s;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        par, par_n;
    logic [7:0]  data_n;
    logic        valid_n, perr_n, ferr_n;
    logic        perr_calc;

    assign rx_s      = sync[1];
    assign perr_calc = (^shreg) ^ par;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= 4'd0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            par       <= 1'b0;
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            sync      <= {sync[0], Rx_D};
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            par       <= par_n;
            Rx_DATA   <= data_n;
            Rx_VALID  <= valid_n;
            Rx_PERROR <= perr_n;
            Rx_FERROR <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        data_n  = Rx_DATA;
        perr_n  = Rx_PERROR;
        ferr_n  = Rx_FERROR;
        valid_n = 1'b0;

        if (!Rx_EN) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            idx_n   = 3'd0;
        end else if (Rx_sample_ENABLE) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = 4'd0;
                    end
                end
                START: begin
                    // Mid-start-bit recheck rejects glitches shorter than half a bit
                    if (cnt != 4'd7) begin
                        cnt_n = cnt + 4'd1;
                    end else if (!rx_s) begin
                        state_n = DATA;
                        cnt_n   = 4'd0;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                DATA: begin
                    if (cnt != 4'd15) begin
                        cnt_n = cnt + 4'd1;
                    end else begin
                        shreg_n[idx] = rx_s;
                        cnt_n        = 4'd0;
                        if (idx == 3'd7) begin
                            state_n = PARITY;
                            idx_n   = 3'd0;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (cnt != 4'd15) begin
                        cnt_n = cnt + 4'd1;
                    end else begin
                        par_n   = rx_s;
                        cnt_n   = 4'd0;
                        state_n = STOP;
                    end
                end
                STOP: begin
                    if (cnt != 4'd15) begin
                        cnt_n = cnt + 4'd1;
                    end else begin
                        data_n  = shreg;
                        perr_n  = perr_calc;
                        ferr_n  = ~rx_s;
                        valid_n = ~perr_calc & rx_s;
                        cnt_n   = 4'd0;
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                    idx_n   = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus random frames against a frame-level model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_EN;
    logic       Rx_sample_ENABLE;
    logic       Rx_D;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int n_cmp = 0;
    int n_err = 0;
    int vhigh = 0;
    int vrise = 0;
    logic [7:0] vdata = 8'h00;
    logic       vprev = 1'b0;

    logic [7:0] exp_data;
    logic       exp_perr, exp_ferr, exp_valid;

    uart_receiver dut (
        .clk              (clk),
        .reset            (reset),
        .Rx_EN            (Rx_EN),
        .Rx_sample_ENABLE (Rx_sample_ENABLE),
        .Rx_D             (Rx_D),
        .Rx_DATA          (Rx_DATA),
        .Rx_VALID         (Rx_VALID),
        .Rx_PERROR        (Rx_PERROR),
        .Rx_FERROR        (Rx_FERROR)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clock in four
    initial begin
        int div;
        div = 0;
        Rx_sample_ENABLE = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            Rx_sample_ENABLE = (div == 0);
        end
    end

    always @(negedge clk) begin
        if (Rx_VALID === 1'b1) begin
            vhigh = vhigh + 1;
            vdata = Rx_DATA;
            if (!vprev) vrise = vrise + 1;
        end
        vprev = (Rx_VALID === 1'b1);
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (Rx_sample_ENABLE !== 1'b1);
        end
        #1;
    endtask

    // Frame-level model: outputs follow directly from the bits on the line
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        exp_data  = d;
        exp_perr  = (^d) ^ p;
        exp_ferr  = ~s;
        exp_valid = ~exp_perr & s;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        Rx_D = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            Rx_D = d[i];
            ticks(16);
        end
        Rx_D = p;
        ticks(16);
        Rx_D = s;
        ticks(16);
        Rx_D = 1'b1;
        ticks(20);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_data"}, {24'd0, Rx_DATA}, {24'd0, exp_data});
        chk({tag, "_perr"}, {31'd0, Rx_PERROR}, {31'd0, exp_perr});
        chk({tag, "_ferr"}, {31'd0, Rx_FERROR}, {31'd0, exp_ferr});
    endtask

    task automatic frame_test(input string tag, input logic [7:0] d, input logic p, input logic s);
        int h0, r0;
        h0 = vhigh;
        r0 = vrise;
        send_frame(d, p, s);
        model_frame(d, p, s);
        chk({tag, "_vcycles"}, vhigh - h0, exp_valid ? 1 : 0);
        chk({tag, "_vpulses"}, vrise - r0, exp_valid ? 1 : 0);
        if (exp_valid) chk({tag, "_vdata"}, {24'd0, vdata}, {24'd0, d});
        check_outputs(tag);
    endtask

    initial begin
        int h0;
        logic [7:0] d;
        logic p, s;

        reset = 1'b1;
        Rx_EN = 1'b1;
        Rx_D  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0;
        check_outputs("reset");
        chk("reset_valid", {31'd0, Rx_VALID}, 32'd0);
        reset = 1'b0;
        ticks(4);

        frame_test("a5_good", 8'hA5, 1'b0, 1'b1);
        frame_test("07_perr", 8'h07, 1'b0, 1'b1);
        frame_test("3c_ferr", 8'h3C, 1'b0, 1'b0);
        frame_test("55_good", 8'h55, 1'b0, 1'b1);

        // Short glitch on the line: rejected at the start-bit recheck
        h0 = vhigh;
        Rx_D = 1'b0;
        ticks(4);
        Rx_D = 1'b1;
        ticks(30);
        chk("glitch_valid", vhigh - h0, 0);
        check_outputs("glitch");
        frame_test("after_glitch", 8'hC3, 1'b0, 1'b1);

        // Reset in the middle of data bit 3 of 0xFF
        h0 = vhigh;
        Rx_D = 1'b0;
        ticks(16);
        for (int i = 0; i < 3; i++) begin
            Rx_D = 1'b1;
            ticks(16);
        end
        Rx_D = 1'b1;
        ticks(8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0;
        check_outputs("midreset");
        chk("midreset_valid", {31'd0, Rx_VALID}, 32'd0);
        ticks(200);
        chk("midreset_novalid", vhigh - h0, 0);
        frame_test("81_after_reset", 8'h81, 1'b0, 1'b1);

        // Rx_EN dropped during the parity bit of 0x12
        model_frame(8'h7E, 1'b0, 1'b1);
        frame_test("prior_7e", 8'h7E, 1'b0, 1'b1);
        h0 = vhigh;
        Rx_D = 1'b0;
        ticks(16);
        d = 8'h12;
        for (int i = 0; i < 8; i++) begin
            Rx_D = d[i];
            ticks(16);
        end
        Rx_D = 1'b0;
        ticks(8);
        Rx_EN = 1'b0;
        ticks(8);
        Rx_D = 1'b1;
        ticks(16);
        chk("en_low_valid", vhigh - h0, 0);
        check_outputs("en_low_hold");
        Rx_EN = 1'b1;
        ticks(20);
        frame_test("12_reenabled", 8'h12, 1'b0, 1'b1);

        // Random frames: mostly clean, some parity/stop errors
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            p = ^d;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 3) != 0);
            frame_test($sformatf("rnd%0d", k), d, p, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
